// File: rtl/zx_pager.sv
// zx_pager: 7FFD/1FFD paging unit for 48K, 128K, +3 and Pentagon-style RAM sizes.
// Maps CPU addresses onto ROM/RAM pages, selects the screen bank and flags contention.
module zx_pager #(
    parameter int MODE  = 1,
    parameter int BANKW = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ce,
    input  logic                iorq,
    input  logic                mreq,
    input  logic                wr,
    input  logic [15:0]         a,
    input  logic [7:0]          d,
    output logic [BANKW+14:0]   memA,
    output logic                memWe,
    output logic [BANKW-1:0]    vduPage,
    output logic                contend,
    output logic                locked,
    output logic [7:0]          p7FFD,
    output logic [7:0]          p1FFD
);

    logic [7:0]       r7ffd;
    logic [7:0]       r1ffd;
    logic             lock;
    logic             taken;

    logic             hit_7ffd;
    logic             hit_1ffd;
    logic [BANKW-1:0] ext_bank;
    logic [1:0]       rom_page;
    logic [2:0]       sp_bank;
    logic             rom;
    logic [BANKW-1:0] page;

    // Port decode; the 128K decode is partial so 1FFD also aliases onto 7FFD
    always_comb begin
        hit_7ffd = 1'b0;
        hit_1ffd = 1'b0;
        if (MODE == 1) begin
            hit_7ffd = !iorq && !wr && !a[15] && !a[1];
        end else if (MODE == 2) begin
            hit_7ffd = !iorq && !wr && (a[15:14] == 2'b01) && !a[1];
            hit_1ffd = !iorq && !wr && (a[15:12] == 4'b0001) && !a[1];
        end
    end

    // Paging registers: one capture per I/O cycle, frozen once locked
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r7ffd <= 8'h00;
            r1ffd <= 8'h00;
            lock  <= 1'b0;
            taken <= 1'b0;
        end else if (ce) begin
            if (iorq) begin
                taken <= 1'b0;
            end else if (!taken && !lock && (hit_7ffd || hit_1ffd)) begin
                taken <= 1'b1;
                if (hit_7ffd) begin
                    r7ffd <= d;
                    if (d[5]) lock <= 1'b1;
                end
                if (hit_1ffd) r1ffd <= d;
            end
        end
    end

    // Extended bank index; cast truncates or zero-extends the 5-bit candidate
    assign ext_bank = BANKW'({r7ffd[7:6], r7ffd[2:0]});

    // ROM page selection per machine
    always_comb begin
        rom_page = 2'b00;
        if (MODE == 1) rom_page = {1'b0, r7ffd[4]};
        else if (MODE == 2) rom_page = {r1ffd[2], r7ffd[4]};
    end

    // +3 all-RAM configurations
    always_comb begin
        sp_bank = 3'd0;
        case (r1ffd[2:1])
            2'b00: sp_bank = {1'b0, a[15:14]};
            2'b01: sp_bank = {1'b1, a[15:14]};
            2'b10: sp_bank = (a[15:14] == 2'b11) ? 3'd3 : {1'b1, a[15:14]};
            default: begin
                case (a[15:14])
                    2'b00:   sp_bank = 3'd4;
                    2'b01:   sp_bank = 3'd7;
                    2'b10:   sp_bank = 3'd6;
                    default: sp_bank = 3'd3;
                endcase
            end
        endcase
    end

    // Slot to physical page mapping
    always_comb begin
        rom  = 1'b0;
        page = '0;
        if ((MODE == 2) && r1ffd[0]) begin
            page = BANKW'(sp_bank);
        end else begin
            case (a[15:14])
                2'b00: begin
                    rom  = 1'b1;
                    page = BANKW'(rom_page);
                end
                2'b01:   page = BANKW'(3'd5);
                2'b10:   page = BANKW'(3'd2);
                default: page = (MODE == 0) ? '0 : ext_bank;
            endcase
        end
    end

    // Contention on the low three bank bits, never on ROM
    always_comb begin
        contend = 1'b0;
        if (!rom) begin
            if (MODE == 0)      contend = (page[2:0] == 3'd5);
            else if (MODE == 1) contend = page[0];
            else                contend = page[2];
        end
    end

    assign memA    = {rom, page, a[13:0]};
    assign memWe   = !mreq && !wr && !rom;
    assign vduPage = ((MODE != 0) && r7ffd[3]) ? BANKW'(7) : BANKW'(5);
    assign locked  = lock;
    assign p7FFD   = r7ffd;
    assign p1FFD   = r1ffd;

endmodule

// File: tb/tb_zx_pager.sv
// Testbench for zx_pager: four configurations driven in parallel, directed
// scenarios plus randomized port writes checked against a rule-level model.
module tb_zx_pager;

    logic        clock = 1'b0;
    logic        reset, ce, iorq, mreq, wr;
    logic [15:0] a;
    logic [7:0]  d;

    logic [17:0] memA0, memA1, memA2;
    logic [19:0] memA3;
    logic        we0, we1, we2, we3;
    logic [2:0]  vdu0, vdu1, vdu2;
    logic [4:0]  vdu3;
    logic        cont0, cont1, cont2, cont3;
    logic        lk0, lk1, lk2, lk3;
    logic [7:0]  p7_0, p7_1, p7_2, p7_3;
    logic [7:0]  p1_0, p1_1, p1_2, p1_3;

    int checks = 0;
    int errors = 0;

    // configuration of each instance
    int imode[4]  = '{0, 1, 2, 1};
    int ibankw[4] = '{3, 3, 3, 5};
    int sp_tbl[4][4] = '{'{0, 1, 2, 3}, '{4, 5, 6, 7}, '{4, 5, 6, 3}, '{4, 7, 6, 3}};

    // reference model state
    int m_r7[4];
    int m_r1[4];
    bit m_lock[4];

    always #5 clock = ~clock;

    zx_pager #(.MODE(0), .BANKW(3)) u0 (.clock(clock), .reset(reset), .ce(ce), .iorq(iorq), .mreq(mreq), .wr(wr),
        .a(a), .d(d), .memA(memA0), .memWe(we0), .vduPage(vdu0), .contend(cont0), .locked(lk0), .p7FFD(p7_0), .p1FFD(p1_0));
    zx_pager #(.MODE(1), .BANKW(3)) u1 (.clock(clock), .reset(reset), .ce(ce), .iorq(iorq), .mreq(mreq), .wr(wr),
        .a(a), .d(d), .memA(memA1), .memWe(we1), .vduPage(vdu1), .contend(cont1), .locked(lk1), .p7FFD(p7_1), .p1FFD(p1_1));
    zx_pager #(.MODE(2), .BANKW(3)) u2 (.clock(clock), .reset(reset), .ce(ce), .iorq(iorq), .mreq(mreq), .wr(wr),
        .a(a), .d(d), .memA(memA2), .memWe(we2), .vduPage(vdu2), .contend(cont2), .locked(lk2), .p7FFD(p7_2), .p1FFD(p1_2));
    zx_pager #(.MODE(1), .BANKW(5)) u3 (.clock(clock), .reset(reset), .ce(ce), .iorq(iorq), .mreq(mreq), .wr(wr),
        .a(a), .d(d), .memA(memA3), .memWe(we3), .vduPage(vdu3), .contend(cont3), .locked(lk3), .p7FFD(p7_3), .p1FFD(p1_3));

    // gather one instance's outputs into common-width values
    task automatic sample(input int k, output bit rom, output int page, output int off, output bit we,
                          output int vdu, output bit cont, output bit lk, output int p7, output int p1);
        case (k)
            0: begin rom = memA0[17]; page = int'(memA0[16:14]); off = int'(memA0[13:0]); we = we0;
                     vdu = int'(vdu0); cont = cont0; lk = lk0; p7 = int'(p7_0); p1 = int'(p1_0); end
            1: begin rom = memA1[17]; page = int'(memA1[16:14]); off = int'(memA1[13:0]); we = we1;
                     vdu = int'(vdu1); cont = cont1; lk = lk1; p7 = int'(p7_1); p1 = int'(p1_1); end
            2: begin rom = memA2[17]; page = int'(memA2[16:14]); off = int'(memA2[13:0]); we = we2;
                     vdu = int'(vdu2); cont = cont2; lk = lk2; p7 = int'(p7_2); p1 = int'(p1_2); end
            default: begin rom = memA3[19]; page = int'(memA3[18:14]); off = int'(memA3[13:0]); we = we3;
                     vdu = int'(vdu3); cont = cont3; lk = lk3; p7 = int'(p7_3); p1 = int'(p1_3); end
        endcase
    endtask

    // expected mapping from the paging rules
    task automatic model_map(input int k, input int addr, output bit rom, output int page);
        int mode, r7, r1, slot;
        mode = imode[k];
        r7   = m_r7[k];
        r1   = m_r1[k];
        slot = (addr >> 14) & 3;
        rom  = 1'b0;
        if (mode == 2 && (r1 & 1) == 1) begin
            page = sp_tbl[(r1 >> 1) & 3][slot];
        end else if (slot == 0) begin
            rom = 1'b1;
            if (mode == 0)      page = 0;
            else if (mode == 1) page = (r7 >> 4) & 1;
            else                page = ((r1 >> 2) & 1) * 2 + ((r7 >> 4) & 1);
        end else if (slot == 1) begin
            page = 5;
        end else if (slot == 2) begin
            page = 2;
        end else if (mode == 0) begin
            page = 0;
        end else begin
            page = (r7 & 7) + 8 * (((r7 >> 6) & 3) % (1 << (ibankw[k] - 3)));
        end
    endtask

    // expected register effect of one complete I/O write cycle
    task automatic model_write(input int k, input int addr, input int data);
        bit low_a1, is7, is1;
        low_a1 = ((addr >> 1) & 1) == 0;
        is7 = 1'b0;
        is1 = 1'b0;
        if (imode[k] == 1) begin
            is7 = ((addr >> 15) & 1) == 0 && low_a1;
        end else if (imode[k] == 2) begin
            is7 = ((addr >> 14) & 3) == 1 && low_a1;
            is1 = ((addr >> 12) & 15) == 1 && low_a1;
        end
        if (!m_lock[k]) begin
            if (is7) begin
                m_r7[k] = data;
                if (((data >> 5) & 1) == 1) m_lock[k] = 1'b1;
            end
            if (is1) m_r1[k] = data;
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        iorq = 1'b1; wr = 1'b1; mreq = 1'b1; ce = 1'b1;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            m_r7[k] = 0; m_r1[k] = 0; m_lock[k] = 1'b0;
        end
    endtask

    task automatic io_write(input logic [15:0] addr, input logic [7:0] data);
        @(negedge clock);
        a = addr; d = data; iorq = 1'b0; wr = 1'b0; mreq = 1'b1; ce = 1'b1;
        repeat (2) @(negedge clock);
        iorq = 1'b1; wr = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_reset();
        bit rom, we, cont, lk; int page, off, vdu, p7, p1;
        do_reset();
        a = 16'hC123; mreq = 1'b0; wr = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            sample(k, rom, page, off, we, vdu, cont, lk, p7, p1);
            checks++;
            if (p7 !== 0 || p1 !== 0 || lk !== 1'b0 || rom !== 1'b0 || page !== 0 || off !== 'h0123 || vdu !== 5) begin
                errors++;
                $display("FAIL reset_c123 k=%0d got p7=%0h p1=%0h lk=%0b rom=%0b page=%0d off=%0h vdu=%0d exp 0/0/0/0/0/123/5",
                         k, p7, p1, lk, rom, page, off, vdu);
            end
        end
        a = 16'h4000;
        #1;
        for (int k = 0; k < 4; k++) begin
            sample(k, rom, page, off, we, vdu, cont, lk, p7, p1);
            checks++;
            if (page !== 5 || cont !== 1'b1 || rom !== 1'b0) begin
                errors++;
                $display("FAIL reset_4000 k=%0d got page=%0d cont=%0b rom=%0b exp 5/1/0", k, page, cont, rom);
            end
        end
        mreq = 1'b1;
    endtask

    task automatic test_mode1_map();
        bit rom, we, cont, lk; int page, off, vdu, p7, p1;
        do_reset();
        io_write(16'h7FFD, 8'h17);
        a = 16'hC000; #1;
        sample(1, rom, page, off, we, vdu, cont, lk, p7, p1);
        checks++;
        if (rom !== 1'b0 || page !== 7 || cont !== 1'b1) begin
            errors++; $display("FAIL m1_c000 got rom=%0b page=%0d cont=%0b exp 0/7/1", rom, page, cont);
        end
        a = 16'h0000; #1;
        sample(1, rom, page, off, we, vdu, cont, lk, p7, p1);
        checks++;
        if (rom !== 1'b1 || page !== 1 || cont !== 1'b0) begin
            errors++; $display("FAIL m1_rom got rom=%0b page=%0d cont=%0b exp 1/1/0", rom, page, cont);
        end
        sample(0, rom, page, off, we, vdu, cont, lk, p7, p1);
        checks++;
        if (p7 !== 0 || page !== 0) begin
            errors++; $display("FAIL m0_ignores got p7=%0h page=%0d exp 0/0", p7, page);
        end
        io_write(16'h7FFD, 8'h08);
        a = 16'hC000; #1;
        sample(1, rom, page, off, we, vdu, cont, lk, p7, p1);
        checks++;
        if (vdu !== 7 || page !== 0 || cont !== 1'b0) begin
            errors++; $display("FAIL m1_screen got vdu=%0d page=%0d cont=%0b exp 7/0/0", vdu, page, cont);
        end
        sample(0, rom, page, off, we, vdu, cont, lk, p7, p1);
        checks++;
        if (vdu !== 5) begin
            errors++; $display("FAIL m0_screen got vdu=%0d exp 5", vdu);
        end
    endtask

    task automatic test_lock();
        bit rom, we, cont, lk; int page, off, vdu, p7, p1;
        do_reset();
        io_write(16'h7FFD, 8'h20);
        io_write(16'h7FFD, 8'h07);
        sample(1, rom, page, off, we, vdu, cont, lk, p7, p1);
        checks++;
        if (p7 !== 'h20 || lk !== 1'b1) begin
            errors++; $display("FAIL lock_hold got p7=%0h lk=%0b exp 20/1", p7, lk);
        end
        @(negedge clock);
        a = 16'h7FFD; d = 8'h07; iorq = 1'b0; wr = 1'b0;
        #2 reset = 1'b1;
        #1;
        sample(1, rom, page, off, we, vdu, cont, lk, p7, p1);
        checks++;
        if (lk !== 1'b0 || p7 !== 0) begin
            errors++; $display("FAIL lock_async_reset got lk=%0b p7=%0h exp 0/0", lk, p7);
        end
        iorq = 1'b1; wr = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_special();
        bit rom, we, cont, lk; int page, off, vdu, p7, p1;
        int exp_pg[4] = '{4, 7, 6, 3};
        do_reset();
        io_write(16'h1FFD, 8'h07);
        mreq = 1'b0; wr = 1'b1;
        for (int s = 0; s < 4; s++) begin
            a = 16'(s * 'h4000 + 'h0155); #1;
            sample(2, rom, page, off, we, vdu, cont, lk, p7, p1);
            checks++;
            if (rom !== 1'b0 || page !== exp_pg[s] || off !== 'h0155) begin
                errors++; $display("FAIL special_slot%0d got rom=%0b page=%0d off=%0h exp 0/%0d/155", s, rom, page, off, exp_pg[s]);
            end
        end
        a = 16'h0000; wr = 1'b0; #1;
        sample(2, rom, page, off, we, vdu, cont, lk, p7, p1);
        checks++;
        if (we !== 1'b1) begin
            errors++; $display("FAIL special_we got %0b exp 1", we);
        end
        sample(1, rom, page, off, we, vdu, cont, lk, p7, p1);
        checks++;
        if (we !== 1'b0 || p7 !== 'h07 || p1 !== 0) begin
            errors++; $display("FAIL m1_alias got we=%0b p7=%0h p1=%0h exp 0/7/0", we, p7, p1);
        end
        a = 16'h4000; wr = 1'b1; #1;
        sample(2, rom, page, off, we, vdu, cont, lk, p7, p1);
        checks++;
        if (cont !== 1'b1 || p7 !== 0 || p1 !== 'h07) begin
            errors++; $display("FAIL special_cont got cont=%0b p7=%0h p1=%0h exp 1/0/7", cont, p7, p1);
        end
        mreq = 1'b1;
    endtask

    task automatic test_single_capture();
        bit rom, we, cont, lk; int page, off, vdu, p7, p1;
        do_reset();
        @(negedge clock);
        a = 16'h7FFD; d = 8'h03; iorq = 1'b0; wr = 1'b0; ce = 1'b1;
        @(negedge clock);
        d = 8'h05;
        repeat (3) @(negedge clock);
        iorq = 1'b1; wr = 1'b1;
        @(negedge clock);
        sample(1, rom, page, off, we, vdu, cont, lk, p7, p1);
        checks++;
        if (p7 !== 'h03) begin
            errors++; $display("FAIL single_capture got p7=%0h exp 03", p7);
        end
        io_write(16'h7FFD, 8'h05);
        sample(1, rom, page, off, we, vdu, cont, lk, p7, p1);
        checks++;
        if (p7 !== 'h05) begin
            errors++; $display("FAIL next_cycle_capture got p7=%0h exp 05", p7);
        end
    endtask

    task automatic test_ce_gate();
        bit rom, we, cont, lk; int page, off, vdu, p7, p1;
        do_reset();
        @(negedge clock);
        ce = 1'b0; a = 16'h7FFD; d = 8'h17; iorq = 1'b0; wr = 1'b0;
        repeat (3) @(negedge clock);
        iorq = 1'b1; wr = 1'b1;
        @(negedge clock);
        ce = 1'b1;
        @(negedge clock);
        sample(1, rom, page, off, we, vdu, cont, lk, p7, p1);
        checks++;
        if (p7 !== 0) begin
            errors++; $display("FAIL ce_gate got p7=%0h exp 00", p7);
        end
    endtask

    task automatic test_bankw5();
        bit rom, we, cont, lk; int page, off, vdu, p7, p1;
        do_reset();
        io_write(16'h7FFD, 8'hC2);
        a = 16'hC000; #1;
        sample(3, rom, page, off, we, vdu, cont, lk, p7, p1);
        checks++;
        if (rom !== 1'b0 || page !== 26 || cont !== 1'b0) begin
            errors++; $display("FAIL bankw5 got rom=%0b page=%0d cont=%0b exp 0/26/0", rom, page, cont);
        end
        sample(1, rom, page, off, we, vdu, cont, lk, p7, p1);
        checks++;
        if (page !== 2) begin
            errors++; $display("FAIL bankw3_trunc got page=%0d exp 2", page);
        end
    endtask

    task automatic test_random();
        bit rom, we, cont, lk, e_rom, e_we, e_cont; int page, off, vdu, p7, p1, e_page, e_vdu;
        logic [15:0] waddr, raddr;
        logic [7:0]  wdata;
        for (int it = 0; it < 40; it++) begin
            if (it % 8 == 0) do_reset();
            case ($urandom_range(0, 2))
                0:       waddr = 16'h7FFD;
                1:       waddr = 16'h1FFD;
                default: waddr = 16'($urandom);
            endcase
            wdata = 8'($urandom);
            if ($urandom_range(0, 3) != 0) wdata[5] = 1'b0;
            io_write(waddr, wdata);
            for (int k = 0; k < 4; k++) model_write(k, int'(waddr), int'(wdata));
            for (int j = 0; j < 4; j++) begin
                @(negedge clock);
                raddr = 16'($urandom);
                a = raddr; mreq = 1'($urandom); wr = 1'($urandom);
                #1;
                for (int k = 0; k < 4; k++) begin
                    sample(k, rom, page, off, we, vdu, cont, lk, p7, p1);
                    model_map(k, int'(raddr), e_rom, e_page);
                    e_we = !mreq && !wr && !e_rom;
                    if (e_rom)               e_cont = 1'b0;
                    else if (imode[k] == 0)  e_cont = (e_page % 8) == 5;
                    else if (imode[k] == 1)  e_cont = (e_page & 1) == 1;
                    else                     e_cont = ((e_page >> 2) & 1) == 1;
                    e_vdu = (imode[k] != 0 && ((m_r7[k] >> 3) & 1) == 1) ? 7 : 5;
                    checks++;
                    if (rom !== e_rom || page !== e_page || off !== int'(raddr[13:0]) || we !== e_we ||
                        cont !== e_cont || vdu !== e_vdu || lk !== m_lock[k] || p7 !== m_r7[k] || p1 !== m_r1[k]) begin
                        errors++;
                        $display("FAIL random it=%0d k=%0d a=%0h got rom=%0b pg=%0d we=%0b ct=%0b vdu=%0d lk=%0b p7=%0h p1=%0h exp rom=%0b pg=%0d we=%0b ct=%0b vdu=%0d lk=%0b p7=%0h p1=%0h",
                                 it, k, raddr, rom, page, we, cont, vdu, lk, p7, p1,
                                 e_rom, e_page, e_we, e_cont, e_vdu, m_lock[k], m_r7[k], m_r1[k]);
                    end
                end
            end
            mreq = 1'b1; wr = 1'b1;
        end
    endtask

    initial begin
        reset = 1'b1; ce = 1'b0; iorq = 1'b1; mreq = 1'b1; wr = 1'b1; a = 16'h0000; d = 8'h00;
        test_reset();
        test_mode1_map();
        test_lock();
        test_special();
        test_single_capture();
        test_ce_gate();
        test_bankw5();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/zx_pager.md
# zx_pager

Parametrised memory paging unit for the Spectrum family cores. It sits between the CPU bus and the `memory` block and decodes the 7FFD and 1FFD paging ports. It maps each CPU address onto a physical ROM/RAM page and tells `vdu` which RAM bank holds the screen. It also flags contended pages for the contention logic. One instance covers 48K, 128K and +3 machines and extended (Pentagon-style) RAM sizes.

## Interface
- `MODE`, default 1: 0 = 48K (ports ignored), 1 = 128K, 2 = +3.
- `BANKW`, default 3: RAM bank index width, from 3 to 6, giving 8 to 64 banks of 16K.
- `clock`  in  1: system clock (56 MHz domain).
- `reset`  in  1: asynchronous, active-high.
- `ce`  in  1: CPU clock-enable (the `cc3M5p` strobe); all register updates are qualified by it.
- `iorq`, `mreq`, `wr`  in  1 each: CPU strobes, active-low.
- `a`  in  16: CPU address.
- `d`  in  8: CPU data out.
- `memA`  out  15+BANKW: physical address {rom, page[BANKW-1:0], a[13:0]}. When rom = 1, only page[1:0] is significant.
- `memWe`  out  1: active-high write enable, = !mreq & !wr & !rom.
- `vduPage`  out  BANKW: screen bank, 5 or 7.
- `contend`  out  1: the page addressed by `a` is contended.
- `locked`  out  1: the paging lock bit.
- `p7FFD`, `p1FFD`  out  8 each: register readback for debug and the OSD.

## Operation
- Registers: r7FFD[7:0], r1FFD[7:0], lock, taken. All four reset to 0.
- Port decode, MODE 1:
  - 7FFD hit = !iorq & !wr & !a[15] & !a[1].
  - 1FFD is not decoded. A write to 1FFD therefore also hits 7FFD, matching real 128K behaviour.
- Port decode, MODE 2:
  - 7FFD hit = !iorq & !wr & a[15:14]==01 & !a[1].
  - 1FFD hit = !iorq & !wr & a[15:12]==0001 & !a[1].
  - The two decodes are mutually exclusive.
- MODE 0: no port is decoded and the registers stay at 0.
- Capture:
  - On a `ce` cycle with a hit, `taken` = 0 and `lock` = 0, the register loads `d` and `taken` sets.
  - `taken` clears on the first `ce` cycle with `iorq` high.
  - Result: exactly one capture per I/O cycle; later `d` changes in the same cycle are ignored.
- Lock:
  - Loading r7FFD with bit 5 = 1 sets `lock`.
  - While `lock` is set, writes to both ports are ignored.
  - Only `reset` clears `lock`.
- Extended banks:
  - Bank index = {r7FFD[7:6] (low BANKW-3 bits used), r7FFD[2:0]}.
  - When BANKW = 3, bits 7:6 are ignored.
  - When BANKW > 5, the upper extension bits are 0.
- Mapping in normal mode (r1FFD[0] = 0, or MODE ≠ 2):
  - 0000-3FFF is ROM.
    - ROM page = 0 in MODE 0.
    - ROM page = {0, r7FFD[4]} in MODE 1.
    - ROM page = {r1FFD[2], r7FFD[4]} in MODE 2.
  - 4000-7FFF is bank 5.
  - 8000-BFFF is bank 2.
  - C000-FFFF is bank 0 in MODE 0, otherwise the extended bank index.
- Mapping in special mode (MODE 2 with r1FFD[0] = 1): all four slots are RAM, selected by r1FFD[2:1].
  - 00 → 0,1,2,3
  - 01 → 4,5,6,7
  - 10 → 4,5,6,3
  - 11 → 4,7,6,3
- Screen: `vduPage` = 7 if r7FFD[3] and MODE ≠ 0, else 5.
- Contention is 0 for ROM. For a RAM bank b:
  - MODE 0: contended only when b = 5.
  - MODE 1: contended when b[0] = 1.
  - MODE 2: contended when b[2] = 1.
  - Only the low 3 bits of b are tested.

## Timing
- `memA`, `memWe`, `contend` and `vduPage` are combinational from `a`, the strobes and the registers, with no pipeline stage.
- A register write is visible on these outputs from the clock edge that captures it, so the next CPU memory cycle already uses the new mapping.
- Asynchronous `reset` forces all registers to 0 immediately, including in the middle of an I/O cycle. The resulting map is ROM0/5/2/0 with screen bank 5.
- Capture requires `ce`. Strobes seen outside `ce` cycles have no effect.
- If a write hits while `lock` is being set by the same capture, that capture still completes; the lock applies from the next I/O cycle.

## Test plan
- Reset: assert `reset` → `p7FFD` = 00, `p1FFD` = 00, `locked` = 0, a = C123 gives `memA` page 0, a = 4000 gives page 5 with `contend` = 1.
- MODE 1, write 0x17 to 7FFD:
  - a = C000 → bank 7, `contend` = 1.
  - a = 0000 → rom = 1, page 1.
  - Then write 0x08 → `vduPage` = 7, C000 → bank 0.
- MODE 1 lock: write 0x20, then 0x07 → `p7FFD` stays 20 and `locked` = 1. Assert `reset` mid-cycle → `locked` = 0 immediately.
- MODE 2, special mode: write 0x07 to 1FFD → slots map to 4,7,6,3, `memWe` = 1 at a = 0000, `contend` = 1 at a = 4000.
- Single capture per I/O cycle: hold `iorq`/`wr` low for 4 `ce` cycles, changing `d` from 0x03 to 0x05 → `p7FFD` = 03.
- BANKW = 5 (32 banks), MODE 1: write 0xC2 → C000 maps bank 26 (binary 11010), `contend` = 0.
